// File: rtl/bus_decoder_pkg.sv
// bus_decoder_pkg: shared types and constants for the bus decoder.
//   state_e            : transaction FSM states
//   SLV_*              : slave port indices of the default memory map
//   *_BASE / *_MASK    : default decode windows (hit when (addr & MASK) == BASE)
//   DEFAULT_BASE/MASK  : packed default tables for a 4-slave, 32-bit build
//   idx_width()        : index width for a given slave count (never 0)
package bus_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    ERR_RSP  = 2'd2
  } state_e;

  localparam int SLV_SRAM  = 0;
  localparam int SLV_UART  = 1;
  localparam int SLV_ACCEL = 2;
  localparam int SLV_TIMER = 3;

  localparam logic [31:0] SRAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] SRAM_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] UART_BASE  = 32'h1000_0000;
  localparam logic [31:0] UART_MASK  = 32'hFFFF_F000;
  localparam logic [31:0] ACCEL_BASE = 32'h2000_0000;
  localparam logic [31:0] ACCEL_MASK = 32'hFFFF_F000;
  localparam logic [31:0] TIMER_BASE = 32'h3000_0000;
  localparam logic [31:0] TIMER_MASK = 32'hFFFF_F000;

  // Slice k of the packed tables belongs to slave index k.
  localparam logic [127:0] DEFAULT_BASE = {TIMER_BASE, ACCEL_BASE, UART_BASE, SRAM_BASE};
  localparam logic [127:0] DEFAULT_MASK = {TIMER_MASK, ACCEL_MASK, UART_MASK, SRAM_MASK};

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_match.sv
// bus_addr_match: combinational base/mask comparator over all slaves with a
// lowest-index priority encoder.
//   addr : address to decode
//   hit  : at least one window matches
//   idx  : lowest matching slave index (0 when no hit)
module bus_addr_match
  import bus_decoder_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = idx_width(NUM_SLAVES),
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] MASK = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  logic [NUM_SLAVES-1:0] match;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_win
    assign match[g] = ((addr & MASK[g*ADDR_W +: ADDR_W]) == BASE[g*ADDR_W +: ADDR_W]);
  end

  // Scan high to low so the last assignment, the lowest index, wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit = 1'b1;
        idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/bus_decoder.sv
// bus_decoder: registered N-slave address decoder between an Ibex-style
// req/gnt/rvalid master and its peripherals. One outstanding transaction.
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   m_*                    : master port (req/gnt request, rvalid response)
//   s_req_o / s_gnt_i      : one-hot slave request, per-slave grant
//   s_we/be/addr/wdata_o   : request payload broadcast to every slave
//   s_rvalid/rdata/err_i   : per-slave responses (rdata packed, slice k = slave k)
//   bus_error_o            : one-cycle pulse with every error response
//   err_addr_o             : address of the most recent erroring transaction
// Optional: define BUS_DECODER_TIMEOUT_EN to abort transactions whose slave
// does not respond within TIMEOUT_CYCLES cycles of the grant.
module bus_decoder
  import bus_decoder_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEFAULT_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = DEFAULT_MASK,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         m_req_i,
  output logic                         m_gnt_o,
  input  logic                         m_we_i,
  input  logic [DATA_W/8-1:0]          m_be_i,
  input  logic [ADDR_W-1:0]            m_addr_i,
  input  logic [DATA_W-1:0]            m_wdata_i,
  output logic                         m_rvalid_o,
  output logic [DATA_W-1:0]            m_rdata_o,
  output logic                         m_err_o,
  output logic [NUM_SLAVES-1:0]        s_req_o,
  input  logic [NUM_SLAVES-1:0]        s_gnt_i,
  output logic                         s_we_o,
  output logic [DATA_W/8-1:0]          s_be_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W-1:0]            s_wdata_o,
  input  logic [NUM_SLAVES-1:0]        s_rvalid_i,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i,
  input  logic [NUM_SLAVES-1:0]        s_err_i,
  output logic                         bus_error_o,
  output logic [ADDR_W-1:0]            err_addr_o
);

  localparam int IDX_W = idx_width(NUM_SLAVES);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, hit_idx;
  logic               hit;
  logic [ADDR_W-1:0]  addr_q, err_addr_q;
  logic [DATA_W-1:0]  sel_rdata;
  logic               go_wait;    // slave accepted the request
  logic               go_err;     // unmapped request accepted locally
  logic               wait_err;   // in-flight transaction ends in error
  logic               expire;

  assign s_we_o     = m_we_i;
  assign s_be_o     = m_be_i;
  assign s_addr_o   = m_addr_i;
  assign s_wdata_o  = m_wdata_i;
  assign err_addr_o = err_addr_q;

  bus_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W),
    .BASE       (SLAVE_BASE),
    .MASK       (SLAVE_MASK)
  ) u_match (
    .addr (m_addr_i),
    .hit  (hit),
    .idx  (hit_idx)
  );

  // Response mux keyed on the registered selection, never the live address.
  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q == IDX_W'(k)) sel_rdata = s_rdata_i[k*DATA_W +: DATA_W];
    end
  end

`ifdef BUS_DECODER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // cnt_q counts completed WAIT_RSP cycles, so the current cycle is number
  // cnt_q+1 after the grant; expiry lands exactly TIMEOUT_CYCLES after it.
  assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      cnt_q <= '0;
    else if (go_wait)               cnt_q <= '0;
    else if (state_q == WAIT_RSP)   cnt_q <= cnt_q + 1'b1;
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Outputs are forced low while reset is held so they drop asynchronously
  // even when the master keeps requesting.
  always_comb begin
    state_d     = state_q;
    m_gnt_o     = 1'b0;
    s_req_o     = '0;
    m_rvalid_o  = 1'b0;
    m_err_o     = 1'b0;
    m_rdata_o   = '0;
    bus_error_o = 1'b0;
    go_wait     = 1'b0;
    go_err      = 1'b0;
    wait_err    = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (m_req_i) begin
            if (hit) begin
              s_req_o[hit_idx] = 1'b1;
              m_gnt_o          = s_gnt_i[hit_idx];
              if (s_gnt_i[hit_idx]) begin
                go_wait = 1'b1;
                state_d = WAIT_RSP;
              end
            end else begin
              m_gnt_o = 1'b1;
              go_err  = 1'b1;
              state_d = ERR_RSP;
            end
          end
        end
        WAIT_RSP: begin
          // A response in the expiry cycle takes precedence over the timeout.
          if (s_rvalid_i[sel_q]) begin
            m_rvalid_o  = 1'b1;
            m_rdata_o   = sel_rdata;
            m_err_o     = s_err_i[sel_q];
            bus_error_o = s_err_i[sel_q];
            wait_err    = s_err_i[sel_q];
            state_d     = IDLE;
          end else if (expire) begin
            m_rvalid_o  = 1'b1;
            m_err_o     = 1'b1;
            bus_error_o = 1'b1;
            wait_err    = 1'b1;
            state_d     = IDLE;
          end
        end
        ERR_RSP: begin
          m_rvalid_o  = 1'b1;
          m_err_o     = 1'b1;
          bus_error_o = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q      <= '0;
      addr_q     <= '0;
      err_addr_q <= '0;
    end else begin
      if (go_wait) begin
        sel_q  <= hit_idx;
        addr_q <= m_addr_i;
      end
      if (go_err)   err_addr_q <= m_addr_i;
      if (wait_err) err_addr_q <= addr_q;
    end
  end

endmodule

// File: tb/tb_bus_decoder.sv
// tb_bus_decoder: directed self-checking bench for bus_decoder.
// Inputs are driven 1 time unit after the rising edge and outputs are
// checked 1 unit later, well clear of the next edge.
module tb_bus_decoder;

  logic         clk, rst;
  logic         m_req, m_gnt, m_we, m_rvalid, m_err;
  logic [3:0]   m_be;
  logic [31:0]  m_addr, m_wdata, m_rdata;
  logic [3:0]   s_req, s_gnt, s_rvalid, s_err, s_be;
  logic         s_we, bus_error;
  logic [31:0]  s_addr, s_wdata, err_addr;
  logic [127:0] s_rdata;

  int checks = 0;
  int errors = 0;

  bus_decoder #(
    .NUM_SLAVES     (4),
    .ADDR_W         (32),
    .DATA_W         (32),
    .SLAVE_BASE     ({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLAVE_MASK     ({32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000}),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m_req_i     (m_req),
    .m_gnt_o     (m_gnt),
    .m_we_i      (m_we),
    .m_be_i      (m_be),
    .m_addr_i    (m_addr),
    .m_wdata_i   (m_wdata),
    .m_rvalid_o  (m_rvalid),
    .m_rdata_o   (m_rdata),
    .m_err_o     (m_err),
    .s_req_o     (s_req),
    .s_gnt_i     (s_gnt),
    .s_we_o      (s_we),
    .s_be_o      (s_be),
    .s_addr_o    (s_addr),
    .s_wdata_o   (s_wdata),
    .s_rvalid_i  (s_rvalid),
    .s_rdata_i   (s_rdata),
    .s_err_i     (s_err),
    .bus_error_o (bus_error),
    .err_addr_o  (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    m_req = 1'b0; m_we = 1'b0; m_be = 4'hF; m_addr = '0; m_wdata = '0;
    s_gnt = '0; s_rvalid = '0; s_err = '0; s_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clr();
    #2;
    rst = 1'b1;
    m_req = 1'b1; m_addr = 32'h0000_0100; s_gnt = 4'hF;
    #1;
    checks++; if (m_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %0h want 0", m_gnt); end
    checks++; if (s_req !== 4'b0000) begin errors++; $display("FAIL reset_sreq: got %b want 0000", s_req); end
    checks++; if (m_rvalid !== 1'b0 || m_err !== 1'b0 || bus_error !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: rvalid %b err %b bus_error %b want 0 0 0", m_rvalid, m_err, bus_error); end
    checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL reset_err_addr: got %h want 0", err_addr); end
    tick(); tick();
    clr();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sram_read();
    m_req = 1'b1; m_addr = 32'h0000_0100; s_gnt = 4'b0001;
    #1;
    checks++; if (s_req !== 4'b0001) begin errors++; $display("FAIL sram_sreq: got %b want 0001", s_req); end
    checks++; if (m_gnt !== 1'b1) begin errors++; $display("FAIL sram_gnt: got %0h want 1", m_gnt); end
    tick();
    // second request presented while the first is outstanding
    m_addr = 32'h1000_0000; s_gnt = 4'hF;
    #1;
    checks++; if (m_gnt !== 1'b0 || s_req !== 4'b0000) begin
      errors++; $display("FAIL sram_stall1: gnt %b sreq %b want 0 0000", m_gnt, s_req); end
    checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL sram_early_rvalid: got %b want 0", m_rvalid); end
    tick();
    s_rvalid = 4'b0001; s_rdata[31:0] = 32'hDEAD_BEEF;
    #1;
    checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sram_rsp: rvalid %b rdata %h want 1 deadbeef", m_rvalid, m_rdata); end
    checks++; if (m_err !== 1'b0 || bus_error !== 1'b0) begin
      errors++; $display("FAIL sram_rsp_err: err %b bus_error %b want 0 0", m_err, bus_error); end
    checks++; if (m_gnt !== 1'b0) begin errors++; $display("FAIL sram_stall2: got %b want 0", m_gnt); end
    tick();
    // stray rvalid in IDLE must not reach the master
    m_req = 1'b0;
    #1;
    checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL idle_stray_rvalid: got %b want 0", m_rvalid); end
    clr();
    tick();
  endtask

  task automatic test_unmapped();
    m_req = 1'b1; m_addr = 32'hF000_0000; s_gnt = 4'hF;
    #1;
    checks++; if (m_gnt !== 1'b1) begin errors++; $display("FAIL miss_gnt: got %b want 1", m_gnt); end
    checks++; if (s_req !== 4'b0000) begin errors++; $display("FAIL miss_sreq: got %b want 0000", s_req); end
    tick();
    clr();
    #1;
    checks++; if (m_rvalid !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'h0) begin
      errors++; $display("FAIL miss_rsp: rvalid %b err %b rdata %h want 1 1 0", m_rvalid, m_err, m_rdata); end
    checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL miss_bus_error: got %b want 1", bus_error); end
    checks++; if (err_addr !== 32'hF000_0000) begin errors++; $display("FAIL miss_err_addr: got %h want f0000000", err_addr); end
    tick();
    #1;
    checks++; if (m_rvalid !== 1'b0 || bus_error !== 1'b0) begin
      errors++; $display("FAIL miss_one_cycle: rvalid %b bus_error %b want 0 0", m_rvalid, bus_error); end
    tick();
  endtask

  task automatic test_gnt_stall();
    m_req = 1'b1; m_we = 1'b1; m_addr = 32'h1000_0004; m_wdata = 32'h0BAD_CAFE; m_be = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (m_gnt !== 1'b0 || s_req !== 4'b0010) begin
        errors++; $display("FAIL uart_wait_gnt[%0d]: gnt %b sreq %b want 0 0010", c, m_gnt, s_req); end
      checks++; if (s_addr !== 32'h1000_0004 || s_wdata !== 32'h0BAD_CAFE || s_we !== 1'b1 || s_be !== 4'b0011) begin
        errors++; $display("FAIL uart_payload[%0d]: addr %h wdata %h we %b be %b", c, s_addr, s_wdata, s_we, s_be); end
      tick();
    end
    s_gnt = 4'b0010;
    #1;
    checks++; if (m_gnt !== 1'b1) begin errors++; $display("FAIL uart_gnt: got %b want 1", m_gnt); end
    tick();
    clr();
    #1;
    checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL uart_early: got %b want 0", m_rvalid); end
    tick();
    s_rvalid = 4'b0010; s_rdata[63:32] = 32'h1234_5678;
    #1;
    checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h1234_5678 || m_err !== 1'b0) begin
      errors++; $display("FAIL uart_rsp: rvalid %b rdata %h err %b want 1 12345678 0", m_rvalid, m_rdata, m_err); end
    tick();
    clr();
    #1;
    checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL uart_single: got %b want 0", m_rvalid); end
    tick();
  endtask

  task automatic test_stray_rvalid();
    m_req = 1'b1; m_addr = 32'h1000_0008; s_gnt = 4'b0010;
    #1;
    checks++; if (m_gnt !== 1'b1) begin errors++; $display("FAIL stray_gnt: got %b want 1", m_gnt); end
    tick();
    clr();
    s_rvalid = 4'b0100; s_err = 4'b0100; s_rdata[95:64] = 32'hBAD0_BAD0;
    #1;
    checks++; if (m_rvalid !== 1'b0 || bus_error !== 1'b0) begin
      errors++; $display("FAIL stray_ignored: rvalid %b bus_error %b want 0 0", m_rvalid, bus_error); end
    tick();
    s_rvalid = 4'b0110; s_err = 4'b0100; s_rdata[63:32] = 32'hCAFE_F00D;
    #1;
    checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hCAFE_F00D || m_err !== 1'b0) begin
      errors++; $display("FAIL stray_rsp: rvalid %b rdata %h err %b want 1 cafef00d 0", m_rvalid, m_rdata, m_err); end
    tick();
    clr();
    tick();
  endtask

  task automatic test_slave_error();
    m_req = 1'b1; m_addr = 32'h2000_0010; s_gnt = 4'b0100;
    #1;
    checks++; if (s_req !== 4'b0100 || m_gnt !== 1'b1) begin
      errors++; $display("FAIL accel_req: sreq %b gnt %b want 0100 1", s_req, m_gnt); end
    tick();
    clr();
    s_rvalid = 4'b0100; s_err = 4'b0100; s_rdata[95:64] = 32'h0000_0055;
    #1;
    checks++; if (m_rvalid !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'h55 || bus_error !== 1'b1) begin
      errors++; $display("FAIL accel_err_rsp: rvalid %b err %b rdata %h bus_error %b want 1 1 55 1", m_rvalid, m_err, m_rdata, bus_error); end
    tick();
    clr();
    #1;
    checks++; if (err_addr !== 32'h2000_0010) begin errors++; $display("FAIL accel_err_addr: got %h want 20000010", err_addr); end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL accel_pulse: got %b want 0", bus_error); end
    tick();
  endtask

  task automatic test_back_to_back();
    m_req = 1'b1; m_addr = 32'h0000_0400; s_gnt = 4'b0001;
    #1;
    checks++; if (m_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt0: got %b want 1", m_gnt); end
    tick();
    m_addr = 32'h3000_0004; s_gnt = 4'b1000; s_rvalid = 4'b0001; s_rdata[31:0] = 32'h0000_0A0A;
    #1;
    checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h0A0A || m_gnt !== 1'b0) begin
      errors++; $display("FAIL b2b_rsp0: rvalid %b rdata %h gnt %b want 1 a0a 0", m_rvalid, m_rdata, m_gnt); end
    tick();
    s_rvalid = '0;
    #1;
    checks++; if (m_gnt !== 1'b1 || s_req !== 4'b1000) begin
      errors++; $display("FAIL b2b_gnt1: gnt %b sreq %b want 1 1000", m_gnt, s_req); end
    tick();
    clr();
    s_rvalid = 4'b1000; s_rdata[127:96] = 32'h0000_0B0B;
    #1;
    checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h0B0B) begin
      errors++; $display("FAIL b2b_rsp1: rvalid %b rdata %h want 1 b0b", m_rvalid, m_rdata); end
    tick();
    clr();
    tick();
  endtask

`ifdef BUS_DECODER_TIMEOUT_EN
  task automatic test_timeout();
    m_req = 1'b1; m_addr = 32'h3000_0000; s_gnt = 4'b1000;
    #1;
    checks++; if (m_gnt !== 1'b1) begin errors++; $display("FAIL to_gnt: got %b want 1", m_gnt); end
    tick();
    clr();
    for (int c = 1; c < 8; c++) begin
      #1;
      checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL to_early[%0d]: got %b want 0", c, m_rvalid); end
      tick();
    end
    #1;
    checks++; if (m_rvalid !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'h0 || bus_error !== 1'b1) begin
      errors++; $display("FAIL to_rsp: rvalid %b err %b rdata %h bus_error %b want 1 1 0 1", m_rvalid, m_err, m_rdata, bus_error); end
    tick();
    s_rvalid = 4'b1000; s_rdata[127:96] = 32'h0000_0777;
    #1;
    checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL to_late_drop: got %b want 0", m_rvalid); end
    checks++; if (err_addr !== 32'h3000_0000) begin errors++; $display("FAIL to_err_addr: got %h want 30000000", err_addr); end
    tick();
    // response in the expiry cycle wins over the timeout
    clr();
    m_req = 1'b1; m_addr = 32'h3000_0008; s_gnt = 4'b1000;
    tick();
    clr();
    for (int c = 1; c < 8; c++) tick();
    s_rvalid = 4'b1000; s_rdata[127:96] = 32'h0000_0077;
    #1;
    checks++; if (m_rvalid !== 1'b1 || m_err !== 1'b0 || m_rdata !== 32'h77 || bus_error !== 1'b0) begin
      errors++; $display("FAIL to_race: rvalid %b err %b rdata %h bus_error %b want 1 0 77 0", m_rvalid, m_err, m_rdata, bus_error); end
    tick();
    clr();
    tick();
  endtask
`else
  task automatic test_timeout();
    logic seen;
    seen = 1'b0;
    m_req = 1'b1; m_addr = 32'h3000_0000; s_gnt = 4'b1000;
    tick();
    clr();
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (m_rvalid !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL no_to_wait: early rvalid %b want 0", seen); end
    s_rvalid = 4'b1000; s_rdata[127:96] = 32'h0000_0321;
    #1;
    checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h321 || m_err !== 1'b0) begin
      errors++; $display("FAIL no_to_rsp: rvalid %b rdata %h err %b want 1 321 0", m_rvalid, m_rdata, m_err); end
    tick();
    clr();
    tick();
  endtask
`endif

  task automatic test_reset_midwait();
    m_req = 1'b1; m_addr = 32'h0000_0200; s_gnt = 4'b0001;
    tick();
    m_addr = 32'h1000_0010; s_gnt = 4'b0010;
    s_rvalid = 4'b0001; s_err = 4'b0001; s_rdata[31:0] = 32'h1111_2222;
    rst = 1'b1;
    #1;
    checks++; if (m_gnt !== 1'b0 || s_req !== 4'b0000) begin
      errors++; $display("FAIL rstw_req: gnt %b sreq %b want 0 0000", m_gnt, s_req); end
    checks++; if (m_rvalid !== 1'b0 || m_err !== 1'b0 || m_rdata !== 32'h0 || bus_error !== 1'b0) begin
      errors++; $display("FAIL rstw_rsp: rvalid %b err %b rdata %h bus_error %b want 0 0 0 0", m_rvalid, m_err, m_rdata, bus_error); end
    checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL rstw_err_addr: got %h want 0", err_addr); end
    tick();
    rst = 1'b0;
    m_req = 1'b0;
    #1;
    checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL rstw_late: got %b want 0", m_rvalid); end
    tick();
    clr();
    m_req = 1'b1; m_addr = 32'h1000_0020; s_gnt = 4'b0010;
    #1;
    checks++; if (s_req !== 4'b0010 || m_gnt !== 1'b1) begin
      errors++; $display("FAIL rstw_new_req: sreq %b gnt %b want 0010 1", s_req, m_gnt); end
    tick();
    clr();
    s_rvalid = 4'b0010; s_rdata[63:32] = 32'h0000_A5A5;
    #1;
    checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hA5A5) begin
      errors++; $display("FAIL rstw_new_rsp: rvalid %b rdata %h want 1 a5a5", m_rvalid, m_rdata); end
    tick();
    clr();
    tick();
  endtask

  initial begin
    test_reset();
    test_sram_read();
    test_unmapped();
    test_gnt_stall();
    test_stray_rvalid();
    test_slave_error();
    test_back_to_back();
    test_timeout();
    test_reset_midwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_decoder.md
Name: bus_decoder

Overview:
- Parametrised, registered successor to the fixed four-slave address decoder.
- Sits between the Ibex data port (req/gnt/rvalid protocol) and N peripheral slaves: SRAM, UART, ACCEL, TIMER and future additions.
- Routes each request to the matching slave and steers that slave's response back to the core.
- Unmapped addresses get a protocol-correct error response instead of a bare bus_error level.
- Optionally, a watchdog aborts transactions to slaves that never respond.

Parameters:
- NUM_SLAVES, 4, number of slave ports.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; BE width is DATA_W/8.
- SLAVE_BASE, packed NUM_SLAVES×ADDR_W, base address per slave.
- SLAVE_MASK, packed NUM_SLAVES×ADDR_W, decode mask per slave; slave k hits when (addr & MASK[k]) == BASE[k].
- TIMEOUT_CYCLES, 256, watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- m_req_i  in  1  master request
- m_gnt_o  out  1  master grant
- m_we_i  in  1  write enable
- m_be_i  in  DATA_W/8  byte enables
- m_addr_i  in  ADDR_W  address
- m_wdata_i  in  DATA_W  write data
- m_rvalid_o  out  1  response valid
- m_rdata_o  out  DATA_W  read data
- m_err_o  out  1  response error
- s_req_o  out  NUM_SLAVES  one-hot slave request
- s_gnt_i  in  NUM_SLAVES  slave grants
- s_we_o, s_be_o, s_addr_o, s_wdata_o  out  as master  broadcast to all slaves
- s_rvalid_i  in  NUM_SLAVES  slave response valids
- s_rdata_i  in  NUM_SLAVES×DATA_W  slave read data, packed
- s_err_i  in  NUM_SLAVES  slave error flags
- bus_error_o  out  1  one-cycle pulse on every error response
- err_addr_o  out  ADDR_W  address of the most recent erroring transaction

Behaviour:
- Decode:
  - Combinational hit vector from m_addr_i.
  - Overlapping hits resolve to the lowest index.
  - Zero hits = miss.
- States: IDLE, WAIT_RSP, ERR_RSP. One outstanding transaction only.
- IDLE, request hits slave k:
  - s_req_o[k] = m_req_i; all other s_req_o bits are 0.
  - m_gnt_o = s_gnt_i[k], combinational, zero-cycle.
  - On m_req_i & s_gnt_i[k]: register sel_q = k and the address, then go to WAIT_RSP.
  - While the slave withholds gnt, remain in IDLE.
- IDLE, request misses:
  - m_gnt_o = 1 in the same cycle; no s_req_o asserted.
  - Latch err_addr_o, go to ERR_RSP.
- ERR_RSP:
  - Drives m_rvalid_o=1, m_err_o=1, m_rdata_o=0 for exactly one cycle.
  - bus_error_o=1 in that cycle.
  - Returns to IDLE.
- WAIT_RSP:
  - m_gnt_o=0 and s_req_o=0, so new requests stall.
  - On s_rvalid_i[sel_q]: m_rvalid_o=1, m_rdata_o = slice sel_q of s_rdata_i, m_err_o = s_err_i[sel_q].
  - If s_err_i[sel_q] is set: bus_error_o pulses and err_addr_o is loaded with the registered address.
  - Same cycle transitions to IDLE; a new request may be granted on the following cycle.
- s_rvalid_i from non-selected slaves is ignored in every state.
- m_rvalid_o is 0 in IDLE, even with a stray slave rvalid present.
- Response latency: slave latency plus 0 cycles (combinational return path). Error response: 1 cycle after grant.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs 0: m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o, s_req_o, bus_error_o, err_addr_o.
  - An in-flight transaction is abandoned; its late response is ignored.
- Outputs are glitch-free with respect to state: the response mux is selected from registered sel_q, not from the live address.

Optional Feature:
- Macro: BUS_DECODER_TIMEOUT_EN.
- When defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entry to WAIT_RSP and increments each WAIT_RSP cycle.
  - When it reaches TIMEOUT_CYCLES without a response, the block drives m_rvalid_o=1, m_err_o=1, m_rdata_o=0, pulses bus_error_o, loads err_addr_o and returns to IDLE.
  - A response arriving in the same cycle as expiry wins (normal response, no timeout).
  - A late response from the timed-out slave is dropped.
- When undefined: no counter logic; WAIT_RSP waits indefinitely.

Decomposition:
- Package bus_decoder_pkg holds:
  - the state enum (IDLE, WAIT_RSP, ERR_RSP);
  - default SRAM/UART/ACCEL/TIMER base and mask constants;
  - slave index constants replacing periph_defs.svh macros.
- Sub-module bus_addr_match: purely combinational parametrised base/mask comparator with lowest-index priority encoder. Outputs hit, idx.

Test Plan:
- Read at 0x0000_0100 with SRAM at index 0 (base 0x0, mask 0xFFFF_0000), slave grants immediately, rvalid 2 cycles later with 0xDEADBEEF -> s_req_o=0001, m_rdata_o=0xDEADBEEF, m_err_o=0, second request stalled until rvalid.
- Access to unmapped 0xF000_0000 -> m_gnt_o same cycle, next cycle m_rvalid_o=1, m_err_o=1, m_rdata_o=0, bus_error_o pulse, err_addr_o=0xF000_0000.
- UART withholds gnt 3 cycles -> m_gnt_o low 3 cycles, address held, grant on cycle 4, single response.
- Stray s_rvalid_i[2] while waiting on slave 1 -> ignored; only slave 1 data returned.
- With BUS_DECODER_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never responds -> error response exactly 8 cycles after grant; late rvalid dropped.
- rst_i asserted mid-WAIT_RSP -> all outputs 0 immediately (asynchronous); next request decodes normally.
